// File: rtl/aes_word_loader.sv
// Word-stream front end for an AES enc/dec core: assembles key and plaintext, drives the core, captures its results.
// Optional round-trip compare of OUT2 against datain1 when AES_LOOPBACK_CHECK_EN is defined.
module aes_word_loader #(
    parameter int RESULT_LATENCY = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode_in,
    input  logic         word_valid,
    input  logic [31:0]  word_in,
    output logic         word_ready,
    output logic [127:0] datain1,
    output logic [127:0] k1,
    output logic [191:0] k2,
    output logic [255:0] k3,
    output logic [1:0]   bits,
    input  logic [127:0] OUT1,
    input  logic [127:0] OUT2,
    output logic [127:0] cipher_out,
    output logic [127:0] plain_out,
    output logic         done,
    output logic         busy,
    output logic         mode_err,
    output logic         match
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_KEY, S_LOAD_DATA, S_WAIT} state_t;

    state_t       r_state;
    state_t       w_state_next;

    logic [1:0]   r_mode;
    logic [255:0] r_key_sr;
    logic [127:0] r_data_sr;
    logic [2:0]   r_key_cnt;
    logic [2:0]   r_data_cnt;
    logic         r_data_full;
    logic [3:0]   r_lat_cnt;
    logic [127:0] r_datain1;
    logic [127:0] r_k1;
    logic [191:0] r_k2;
    logic [255:0] r_k3;
    logic [1:0]   r_bits;
    logic [127:0] r_cipher;
    logic [127:0] r_plain;

    logic [2:0]   w_key_last_idx;
    logic         w_word_ready;
    logic         w_accept;
    logic         w_start_ok;
    logic         w_load_out;
    logic         w_capture;

    // Last key-word index: NK-1 for NK = 4/6/8.
    always_comb begin
        case (r_mode)
            2'd1:    w_key_last_idx = 3'd5;
            2'd2:    w_key_last_idx = 3'd7;
            default: w_key_last_idx = 3'd3;
        endcase
    end

    assign w_start_ok = start && (mode_in != 2'd3);
    assign w_accept   = word_valid && w_word_ready;
    assign w_load_out = (r_state == S_LOAD_DATA) && r_data_full;
    assign w_capture  = (r_state == S_WAIT) && (r_lat_cnt == 4'(RESULT_LATENCY - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start_ok) w_state_next = S_LOAD_KEY;
            S_LOAD_KEY:  if (w_accept && (r_key_cnt == w_key_last_idx)) w_state_next = S_LOAD_DATA;
            S_LOAD_DATA: if (r_data_full) w_state_next = S_WAIT;
            S_WAIT:      if (w_capture) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Status outputs are suppressed while reset is held so an aborted capture cycle never shows done.
    always_comb begin
        w_word_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        mode_err     = 1'b0;
        if (!reset) begin
            w_word_ready = (r_state == S_LOAD_KEY) || ((r_state == S_LOAD_DATA) && !r_data_full);
            busy         = (r_state != S_IDLE);
            done         = w_capture;
            mode_err     = (r_state == S_IDLE) && start && (mode_in == 2'd3);
        end
    end

    assign word_ready = w_word_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode      <= '0;
            r_key_sr    <= '0;
            r_data_sr   <= '0;
            r_key_cnt   <= '0;
            r_data_cnt  <= '0;
            r_data_full <= 1'b0;
            r_lat_cnt   <= '0;
            r_datain1   <= '0;
            r_k1        <= '0;
            r_k2        <= '0;
            r_k3        <= '0;
            r_bits      <= '0;
            r_cipher    <= '0;
            r_plain     <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_mode      <= mode_in;
                r_key_sr    <= '0;
                r_data_sr   <= '0;
                r_key_cnt   <= '0;
                r_data_cnt  <= '0;
                r_data_full <= 1'b0;
            end
            if ((r_state == S_LOAD_KEY) && w_accept) begin
                r_key_sr  <= {r_key_sr[223:0], word_in};
                r_key_cnt <= (r_key_cnt == w_key_last_idx) ? 3'd0 : r_key_cnt + 3'd1;
            end
            if ((r_state == S_LOAD_DATA) && w_accept) begin
                r_data_sr <= {r_data_sr[95:0], word_in};
                if (r_data_cnt == 3'd3) begin
                    r_data_full <= 1'b1;
                end else begin
                    r_data_cnt <= r_data_cnt + 3'd1;
                end
            end
            // The shift registers start cleared, so unused upper key bits come out as zero.
            if (w_load_out) begin
                r_datain1   <= r_data_sr;
                r_k1        <= r_key_sr[127:0];
                r_k2        <= r_key_sr[191:0];
                r_k3        <= r_key_sr;
                r_bits      <= r_mode;
                r_lat_cnt   <= '0;
                r_data_full <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end
            if (w_capture) begin
                r_cipher <= OUT1;
                r_plain  <= OUT2;
            end
        end
    end

`ifdef AES_LOOPBACK_CHECK_EN
    logic r_match;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_match <= 1'b0;
        end else if (w_capture) begin
            r_match <= (OUT2 == r_datain1);
        end
    end
    assign match = r_match;
`else
    assign match = 1'b0;
`endif

    assign datain1    = r_datain1;
    assign k1         = r_k1;
    assign k2         = r_k2;
    assign k3         = r_k3;
    assign bits       = r_bits;
    assign cipher_out = r_cipher;
    assign plain_out  = r_plain;

endmodule

// File: tb/tb_aes_word_loader.sv
// Scoreboard bench for aes_word_loader with a registered AES core stub (known-answer vectors).
module tb_aes_word_loader;

    localparam int LAT = 2;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_LOOPBACK_CHECK_EN
    localparam logic EXP_MATCH = 1'b1;
`else
    localparam logic EXP_MATCH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, word_valid, word_ready;
    logic [1:0]   mode_in, bits;
    logic [31:0]  word_in;
    logic [127:0] datain1, k1, OUT1, OUT2, cipher_out, plain_out;
    logic [191:0] k2;
    logic [255:0] k3;
    logic         done, busy, mode_err, match;

    always #5 clk = ~clk;

    aes_word_loader #(.RESULT_LATENCY(LAT)) dut (
        .clock(clk), .reset(reset), .start(start), .mode_in(mode_in),
        .word_valid(word_valid), .word_in(word_in), .word_ready(word_ready),
        .datain1(datain1), .k1(k1), .k2(k2), .k3(k3), .bits(bits),
        .OUT1(OUT1), .OUT2(OUT2), .cipher_out(cipher_out), .plain_out(plain_out),
        .done(done), .busy(busy), .mode_err(mode_err), .match(match)
    );

    // Core stub: one-cycle registered encrypt (known-answer lookup) plus ideal decrypt.
    always @(posedge clk) begin
        OUT2 <= datain1;
        case (bits)
            2'd0:    OUT1 <= (k1 == K128 && datain1 == PT) ? C128 : ~datain1;
            2'd1:    OUT1 <= (k2 == K192 && datain1 == PT) ? C192 : ~datain1;
            2'd2:    OUT1 <= (k3 == K256 && datain1 == PT) ? C256 : ~datain1;
            default: OUT1 <= ~datain1;
        endcase
    end

    typedef struct {
        logic [127:0] din;
        logic [127:0] k1;
        logic [191:0] k2;
        logic [255:0] k3;
        logic [1:0]   bits;
        logic [127:0] cipher;
        logic [127:0] plain;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    bit   cap_pending = 1'b0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (cap_pending) begin
            check_eq("cipher_out", 256'(cipher_out), 256'(cur.cipher));
            check_eq("plain_out", 256'(plain_out), 256'(cur.plain));
            check_eq("match", 256'(match), 256'(EXP_MATCH));
            cap_pending = 1'b0;
        end
        if (word_valid && word_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            check_eq("done_latency", 256'(cyc - last_acc_cyc), 256'(LAT + 1));
            check_eq("sb_nonempty", 256'(exp_q.size() != 0), 256'(1));
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                check_eq("datain1", 256'(datain1), 256'(cur.din));
                check_eq("k1", 256'(k1), 256'(cur.k1));
                check_eq("k2", 256'(k2), 256'(cur.k2));
                check_eq("k3", k3, cur.k3);
                check_eq("bits", 256'(bits), 256'(cur.bits));
                cap_pending = 1'b1;
                $display("done: mode %0d cipher expected %h", cur.bits, cur.cipher);
            end
        end
    end

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_busy"}, 256'(busy), 256'(0));
        check_eq({pfx, "_word_ready"}, 256'(word_ready), 256'(0));
        check_eq({pfx, "_done"}, 256'(done), 256'(0));
        check_eq({pfx, "_datain1"}, 256'(datain1), 256'(0));
        check_eq({pfx, "_keys"}, 256'(k1) | 256'(k2) | k3, 256'(0));
        check_eq({pfx, "_bits"}, 256'(bits), 256'(0));
        check_eq({pfx, "_results"}, 256'(cipher_out | plain_out), 256'(0));
        check_eq({pfx, "_match"}, 256'(match), 256'(0));
    endtask

    task automatic do_xfer(input logic [1:0] mode, input logic [255:0] key, input int nk,
                           input bit gaps, input bit start_in_wait, input logic [127:0] c_exp);
        logic [31:0]  words [12];
        logic [127:0] pt_v;
        exp_t         e;
        int           i, t, acc0, d0;
        pt_v = PT;
        for (int j = 0; j < nk; j++) words[j] = key[(nk - 1 - j) * 32 +: 32];
        for (int j = 0; j < 4; j++) words[nk + j] = pt_v[(3 - j) * 32 +: 32];
        e.din = pt_v; e.k1 = key[127:0]; e.k2 = key[191:0]; e.k3 = key;
        e.bits = mode; e.cipher = c_exp; e.plain = pt_v;
        exp_q.push_back(e);
        acc0 = acc_cnt;
        d0 = done_cnt;
        start = 1'b1; mode_in = mode;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check_eq("busy_after_start", 256'(busy), 256'(1));
        @(posedge clk); #1;
        i = 0; t = 0;
        while (i < nk + 4 && t < 400) begin
            word_valid = gaps ? ((t % 2) == 0) : 1'b1;
            word_in = words[i];
            @(negedge clk);
            if (word_valid && word_ready) i++;
            @(posedge clk); #1;
            t++;
        end
        word_valid = 1'b0;
        check_eq("stream_complete", 256'(i), 256'(nk + 4));
        if (start_in_wait) start = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 50);
        check_eq("done_seen", 256'(done), 256'(1));
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); check_eq("idle_after_done", 256'(busy), 256'(0));
        @(negedge clk); check_eq("busy_stays_low", 256'(busy), 256'(0));
        check_eq("words_accepted", 256'(acc_cnt - acc0), 256'(nk + 4));
        check_eq("done_pulses", 256'(done_cnt - d0), 256'(1));
        $display("xfer mode %0d: %0d words accepted, %0d done pulse(s)", mode, acc_cnt - acc0, done_cnt - d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, n;
        reset = 1'b1; start = 1'b0; mode_in = 2'd0; word_valid = 1'b0; word_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("reset");
        $display("reset: outputs checked");

        do_xfer(2'd0, 256'(K128), 4, 1'b0, 1'b0, C128);
        do_xfer(2'd2, K256, 8, 1'b0, 1'b0, C256);
        do_xfer(2'd1, 256'(K192), 6, 1'b1, 1'b0, C192);

        // Illegal mode: single mode_err pulse, nothing else moves.
        @(posedge clk); #1 start = 1'b1; mode_in = 2'd3;
        @(negedge clk);
        check_eq("mode_err_pulse", 256'(mode_err), 256'(1));
        check_eq("mode_err_busy", 256'(busy), 256'(0));
        check_eq("mode_err_ready", 256'(word_ready), 256'(0));
        @(posedge clk); #1 start = 1'b0; mode_in = 2'd0;
        @(negedge clk);
        check_eq("mode_err_clear", 256'(mode_err), 256'(0));
        check_eq("mode_err_busy2", 256'(busy), 256'(0));
        check_eq("mode_err_cipher_held", 256'(cipher_out), 256'(C192));
        check_eq("mode_err_bits_held", 256'(bits), 256'(1));
        $display("illegal mode: checked");

        // Abort after the third key word.
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1; mode_in = 2'd0;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        for (int t = 0; t < 20 && n < 3; t++) begin
            word_valid = 1'b1;
            word_in = 32'h00010203 + 32'(n) * 32'h04040404;
            @(negedge clk);
            if (word_valid && word_ready) n++;
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_zero("abort");
        repeat (6) @(negedge clk);
        check_eq("abort_no_done", 256'(done_cnt - d0), 256'(0));
        $display("abort after %0d key words: checked", n);

        do_xfer(2'd0, 256'(K128), 4, 1'b0, 1'b0, C128);
        do_xfer(2'd0, 256'(K128), 4, 1'b0, 1'b1, C128);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
